conv2d_3x3_engine_param: RTL and testbench

CONV2D_3X3_ENGINE_PARAM -- requirements
Module: conv2d_3x3_engine_param

---
 rtl/conv2d_3x3_engine_param.sv | 192 +++++++++++++++++++
 tb/tb_conv2d_3x3_engine_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_3x3_engine_param.sv
// 3x3 valid-padding, stride-1 convolution engine: one MAC per cycle, 11 cycles per output.
// Define CONV2D_RELU_EN for ReLU + unsigned saturation; otherwise signed saturation.
module conv2d_3x3_engine_param #(
    parameter int unsigned IN_W   = 28,
    parameter int unsigned IN_H   = 28,
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SHIFT  = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [31:0]       read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned OUT_W   = IN_W - 2;
    localparam int unsigned OUT_H   = IN_H - 2;
    localparam int unsigned IMG_D   = IN_W * IN_H;
    localparam int unsigned WGT_D   = NUM_CH * 9;
    localparam int unsigned OUT_D   = NUM_CH * OUT_H * OUT_W;
    localparam int unsigned IMG_AW  = (IMG_D > 1) ? $clog2(IMG_D) : 1;
    localparam int unsigned WGT_AW  = (WGT_D > 1) ? $clog2(WGT_D) : 1;
    localparam int unsigned BIAS_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned OUT_AW  = (OUT_D > 1) ? $clog2(OUT_D) : 1;
    localparam int unsigned PW      = 2 * DATA_W + 2;

`ifdef CONV2D_RELU_EN
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << DATA_W) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = '0;
`else
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;
`endif

    typedef enum logic [2:0] {StIdle, StInit, StMac, StWrite, StDone} state_e;

    logic [DATA_W-1:0]        img_mem  [IMG_D];
    logic signed [DATA_W-1:0] wgt_mem  [WGT_D];
    logic signed [ACC_W-1:0]  bias_mem [NUM_CH];
    logic [DATA_W-1:0]        out_mem  [OUT_D];

    state_e                  state_q, state_d;
    logic [31:0]             c_q, c_d, r_q, r_d, ch_q, ch_d;
    logic [1:0]              kx_q, kx_d, ky_q, ky_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0]       read_data_q, read_data_d;

    logic [31:0]             img_idx, wgt_idx, out_idx;
    logic signed [DATA_W:0]  pix_s, wgt_s;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] shifted, q;
    logic                    unused_bits;

    always_comb begin
        img_idx = (r_q + 32'(ky_q)) * IN_W + c_q + 32'(kx_q);
        wgt_idx = ch_q * 9 + 32'(ky_q) * 3 + 32'(kx_q);
        out_idx = ch_q * (OUT_H * OUT_W) + r_q * OUT_W + c_q;
        // Pixel is zero-extended so the product is signed x unsigned.
        pix_s   = signed'({1'b0, img_mem[img_idx[IMG_AW-1:0]]});
        wgt_s   = (DATA_W + 1)'(wgt_mem[wgt_idx[WGT_AW-1:0]]);
        prod    = PW'(pix_s) * PW'(wgt_s);
        shifted = acc_q >>> SHIFT;
        if (shifted < Q_MIN) begin
            q = Q_MIN;
        end else if (shifted > Q_MAX) begin
            q = Q_MAX;
        end else begin
            q = shifted;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        ch_d    = ch_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StInit;
                    c_d     = '0;
                    r_d     = '0;
                    ch_d    = '0;
                end
            end
            StInit: begin
                acc_d   = bias_mem[ch_q[BIAS_AW-1:0]];
                kx_d    = '0;
                ky_d    = '0;
                state_d = StMac;
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                if (kx_q == 2'd2) begin
                    kx_d = '0;
                    if (ky_q == 2'd2) begin
                        ky_d    = '0;
                        state_d = StWrite;
                    end else begin
                        ky_d = ky_q + 2'd1;
                    end
                end else begin
                    kx_d = kx_q + 2'd1;
                end
            end
            StWrite: begin
                state_d = StInit;
                if (c_q == OUT_W - 1) begin
                    c_d = '0;
                    if (r_q == OUT_H - 1) begin
                        r_d = '0;
                        if (ch_q == NUM_CH - 1) begin
                            ch_d    = '0;
                            state_d = StDone;
                        end else begin
                            ch_d = ch_q + 32'd1;
                        end
                    end else begin
                        r_d = r_q + 32'd1;
                    end
                end else begin
                    c_d = c_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d      = (state_d == StInit) || (state_d == StMac) || (state_d == StWrite);
        done_d      = (state_d == StDone);
        read_data_d = (read_addr < OUT_D) ? out_mem[read_addr[OUT_AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            c_q         <= '0;
            r_q         <= '0;
            ch_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            ch_q        <= ch_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
        end
    end

    // Memories keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            case (wr_sel)
                2'd0: if (wr_addr < IMG_D) img_mem[wr_addr[IMG_AW-1:0]] <= wr_data[DATA_W-1:0];
                2'd1: if (wr_addr < WGT_D) wgt_mem[wr_addr[WGT_AW-1:0]] <= wr_data[DATA_W-1:0];
                2'd2: if (wr_addr < NUM_CH) bias_mem[wr_addr[BIAS_AW-1:0]] <= wr_data[ACC_W-1:0];
                default: ;
            endcase
        end
        if (state_q == StWrite) begin
            out_mem[out_idx[OUT_AW-1:0]] <= q[DATA_W-1:0];
        end
    end

    assign unused_bits = ^{wr_data[31:ACC_W], img_idx[31:IMG_AW], wgt_idx[31:WGT_AW],
                           out_idx[31:OUT_AW], q[ACC_W-1:DATA_W]};

    assign read_data = read_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv2d_3x3_engine_param.sv
// Directed bench for conv2d_3x3_engine_param on a 5x5 image with 3 channels.
module tb_conv2d_3x3_engine_param;

    localparam int OUT_D   = 27;
    localparam int RUN_CYC = 297;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] read_addr = '0;
    logic [7:0]  read_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    conv2d_3x3_engine_param #(
        .IN_W(5), .IN_H(5), .NUM_CH(3), .DATA_W(8), .ACC_W(24), .SHIFT(0)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .read_addr(read_addr),
        .read_data(read_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] clamp8(input int x);
`ifdef CONV2D_RELU_EN
        if (x < 0) x = 0;
        if (x > 255) x = 255;
`else
        if (x < -128) x = -128;
        if (x > 127) x = 127;
`endif
        return 8'(x);
    endfunction

    // ch0 weights +1 (bias b0), ch1 weights -1, ch2 weights +127; ramp image pixel = r*5+c.
    function automatic logic [7:0] exp_out(input int a, input int b0, input bit ramp);
        int ch, p, r, c, v;
        ch = a / 9;
        p  = a % 9;
        r  = p / 3;
        c  = p % 3;
        v  = ramp ? 9 * (5 * r + c) + 54 : 9;
        if (ch == 0) return clamp8(v + b0);
        if (ch == 1) return clamp8(-v);
        return clamp8(127 * v);
    endfunction

    task automatic wr(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [7:0] data);
        @(negedge clk);
        read_addr = addr;
        @(posedge clk);
        #1 data = read_data;
    endtask

    task automatic run(input bit inject, output int cycles);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_start: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        while (!seen && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (inject && n == 100) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 0; wr_data = 200;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: done not seen in %0d cycles, required %0d", n, RUN_CYC);
        end
        cycles = n;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++;
        if (read_data !== 8'h00) begin
            errors++; $display("FAIL reset_read_data: got %h, required 00", read_data);
        end
        resetn = 1'b1;
    endtask

    task automatic test_uniform();
        int cyc;
        logic [7:0] d;
        for (int i = 0; i < 25; i++) wr(2'd0, i, 1);
        for (int k = 0; k < 9; k++) begin
            wr(2'd1, k, 1);
            wr(2'd1, 9 + k, 32'hFFFF_FFFF);
            wr(2'd1, 18 + k, 127);
        end
        for (int ch = 0; ch < 3; ch++) wr(2'd2, ch, 0);
        run(1'b0, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++; $display("FAIL uniform_cycles: got %0d, required %0d", cyc, RUN_CYC);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL uniform_busy_end: got %b, required 0", busy); end
        for (int a = 0; a < OUT_D; a++) begin
            rd(a, d);
            checks++;
            if (d !== exp_out(a, 0, 1'b0)) begin
                errors++; $display("FAIL uniform_out[%0d]: got %h, required %h", a, d, exp_out(a, 0, 1'b0));
            end
        end
    endtask

    task automatic test_read_range();
        logic [7:0] d;
        rd(0, d);
        checks++;
        if (d !== exp_out(0, 0, 1'b0)) begin errors++; $display("FAIL read_addr0: got %h", d); end
        rd(OUT_D, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL read_oob_27: got %h, required 00", d); end
        rd(32'hFFFF_FFFF, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL read_oob_max: got %h, required 00", d); end
    endtask

    task automatic check_ramp(input int b0, input string tag);
        logic [7:0] d;
        for (int a = 0; a < OUT_D; a++) begin
            rd(a, d);
            checks++;
            if (d !== exp_out(a, b0, 1'b1)) begin
                errors++;
                $display("FAIL %s_out[%0d]: got %h, required %h", tag, a, d, exp_out(a, b0, 1'b1));
            end
        end
    endtask

    task automatic test_ramp_bias();
        int cyc;
        for (int i = 0; i < 25; i++) wr(2'd0, i, i);
        wr(2'd2, 0, -40);
        run(1'b0, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++; $display("FAIL ramp_cycles: got %0d, required %0d", cyc, RUN_CYC);
        end
        check_ramp(-40, "ramp");
    endtask

    task automatic test_ignored_writes();
        int cyc;
        wr(2'd3, 0, 200);
        wr(2'd0, 25, 200);
        wr(2'd0, 32, 200);
        wr(2'd1, 32, 0);
        wr(2'd2, 4, 100);
        run(1'b0, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++; $display("FAIL ignored_cycles: got %0d, required %0d", cyc, RUN_CYC);
        end
        check_ramp(-40, "ignored");
    endtask

    task automatic test_start_during_run();
        int cyc;
        run(1'b1, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++; $display("FAIL midstart_cycles: got %0d, required %0d", cyc, RUN_CYC);
        end
        check_ramp(-40, "midstart");
    endtask

    task automatic test_mid_reset();
        int cyc;
        wr(2'd2, 0, -30);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1 read_addr = 5;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || read_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b read_data=%h, required 0 0 00",
                     busy, done, read_data);
        end
        resetn = 1'b1;
        run(1'b0, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++; $display("FAIL midreset_cycles: got %0d, required %0d", cyc, RUN_CYC);
        end
        check_ramp(-30, "midreset");
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_read_range();
        test_ramp_bias();
        test_ignored_writes();
        test_start_during_run();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
